dac_spi_driver: RTL
===================

// Module: dac_spi_driver
// PURPOSE
//  Downstream of the DDS top-level output mux. Serialises the 16-bit selected waveform
//  sample (SignalOut) into a 24-bit SPI frame for an external 16-bit DAC.
//  Frames repeat back-to-back while enabled; each frame samples and holds one DDS output
//  word. This sets the DAC update rate independently of the DDS clock.
// PARAMETERS
//  CLK_DIV     2      clk cycles per SCLK half-period; legal range >=1
//  GAP_CYCLES  4      clk cycles sync_n stays high between frames; legal range >=1
//  CMD_BYTE    8'h00  upper 8 frame bits (DAC control byte), sent MSB first
//  TWOS_COMP   0      1: sample_in is two's complement; MSB inverted to offset binary
// PORTS
//  clk         in   1   system clock, same domain as the DDS core
//  reset       in   1   asynchronous, active-high
//  enable      in   1   1: run continuous frames; sampled only in IDLE
//  sample_in   in   16  DDS output word (SignalOut)
//  sclk        out  1   SPI clock, idles high
//  sync_n      out  1   frame select, active low
//  din         out  1   serial data, MSB first
//  busy        out  1   1 whenever state != IDLE
//  frame_done  out  1   1-cycle pulse when the last bit's low phase ends
// BEHAVIOUR
//  Reset (async, any state): IDLE; sclk=1, sync_n=1, din=0, busy=0, frame_done=0,
//   counters=0. Outputs are registered, with no combinational path from inputs.
//  Frame word = {CMD_BYTE, TWOS_COMP ? {~sample_in[15], sample_in[14:0]} : sample_in}.
//  States: IDLE -> SHIFT -> GAP -> IDLE.
//   IDLE : if enable, then on the next edge: capture the frame word into a 24-bit shift
//          register, enter SHIFT, sync_n=0, sclk=1, din=frame[23].
//   SHIFT: each bit takes 2*CLK_DIV cycles. sclk=1 for CLK_DIV cycles, then sclk=0 for
//          CLK_DIV cycles. The DAC captures on the sclk falling edge.
//          din changes only when sclk rises to the next bit, so din is stable
//          across the falling edge. After bit 0's low phase: sclk=1, sync_n=1, din=0,
//          frame_done=1 for 1 cycle, then enter GAP.
//   GAP  : hold sync_n=1 for GAP_CYCLES cycles, then enter IDLE.
//  Timing: SHIFT lasts exactly 24*2*CLK_DIV cycles.
//   Steady-state frame period = 48*CLK_DIV + GAP_CYCLES + 1 cycles
//   (101 cycles with the defaults).
//  Changes to sample_in during SHIFT or GAP do not affect the frame in flight.
//  Deasserting enable mid-frame completes the frame and GAP, then stays in IDLE.
//  A 1-cycle enable pulse in IDLE starts exactly one frame.
//  Reset mid-frame truncates the frame (sync_n rises immediately); no frame_done.
//  Bit counter (5 bits) and half-period counter ($clog2(CLK_DIV+1) bits) must not wrap
//   inside a frame. Assertion: sync_n=0 implies state==SHIFT.
// STRUCTURE
//  Package dds_dac_pkg: state encoding (IDLE/SHIFT/GAP), FRAME_BITS=24, DATA_BITS=16,
//   CMD_BITS=8.
//  Sub-module dac_bit_timer: CLK_DIV half-period counter issuing rise/fall strobes.
//   Cleared on SHIFT entry.
//  This module holds the FSM, the shift register, the bit counter and the gap counter.
// TESTING
//  1 Defaults, enable=1, sample_in=16'hA5C3 -> SPI monitor decodes 24'h00A5C3,
//    sync_n low for 96 cycles, frame_done every 101 cycles.
//  2 TWOS_COMP=1, sample_in=16'h8000 then 16'h7FFF -> payloads 16'h0000 then 16'hFFFF;
//    sample_in=0 -> 16'h8000.
//  3 sample_in toggled every cycle during SHIFT -> transmitted word equals the value
//    at IDLE->SHIFT; din constant for 2*CLK_DIV cycles per bit.
//  4 enable dropped at bit 10 -> frame completes, 1 frame_done, then busy=0,
//    and sync_n stays high.
//  5 reset asserted at bit 5 -> same cycle sync_n=1, sclk=1, din=0; no frame_done;
//    after release with enable=1 the next frame is complete and correct.
//  6 CLK_DIV=1, GAP_CYCLES=1 -> 50-cycle period; sclk toggles every cycle; 24 falling
//    edges per frame.

Source files
------------

// File: rtl/dds_dac_pkg.sv
// rtl/dds_dac_pkg.sv - shared state encoding, frame geometry and frame builder for the DAC SPI driver
package dds_dac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } stateT;

  localparam int FRAME_BITS = 24;
  localparam int DATA_BITS  = 16;
  localparam int CMD_BITS   = 8;

  // Two's complement samples become offset binary by flipping the sign bit.
  function automatic logic [FRAME_BITS-1:0] buildFrame(
    input logic [CMD_BITS-1:0]  cmd,
    input logic [DATA_BITS-1:0] sample,
    input logic                 twosComp
  );
    return {cmd, twosComp ? {~sample[DATA_BITS-1], sample[DATA_BITS-2:0]} : sample};
  endfunction

endpackage

// File: rtl/dac_bit_timer.sv
// rtl/dac_bit_timer.sv - SCLK half-period counter issuing fall/rise strobes while a frame shifts
module dac_bit_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic fallStb,
  output logic riseStb
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);

  logic [CNT_W-1:0] halfCnt;
  logic             lowPhase;
  logic             halfEnd;

  assign halfEnd = run && (halfCnt == CNT_W'(CLK_DIV - 1));
  assign fallStb = halfEnd && !lowPhase;
  assign riseStb = halfEnd && lowPhase;

  // Held clear outside SHIFT so every frame starts at the top of a high phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halfCnt  <= '0;
      lowPhase <= 1'b0;
    end else if (!run) begin
      halfCnt  <= '0;
      lowPhase <= 1'b0;
    end else if (halfEnd) begin
      halfCnt  <= '0;
      lowPhase <= ~lowPhase;
    end else begin
      halfCnt <= halfCnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dac_spi_driver.sv
// rtl/dac_spi_driver.sv - serialises one held DDS sample per 24-bit SPI frame for a 16-bit DAC
module dac_spi_driver
  import dds_dac_pkg::*;
#(
  parameter int                  CLK_DIV    = 2,
  parameter int                  GAP_CYCLES = 4,
  parameter logic [CMD_BITS-1:0] CMD_BYTE   = 8'h00,
  parameter bit                  TWOS_COMP  = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DATA_BITS-1:0] sample_in,
  output logic                 sclk,
  output logic                 sync_n,
  output logic                 din,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  stateT                 state;
  logic [FRAME_BITS-1:0] shiftReg;
  logic [FRAME_BITS-1:0] frameWord;
  logic [4:0]            bitCnt;
  logic [GAP_W-1:0]      gapCnt;
  logic                  fallStb;
  logic                  riseStb;

  assign frameWord = buildFrame(CMD_BYTE, sample_in, TWOS_COMP);

  dac_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) bitTimer (
    .clk    (clk),
    .reset  (reset),
    .run    (state == SHIFT),
    .fallStb(fallStb),
    .riseStb(riseStb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shiftReg   <= '0;
      bitCnt     <= '0;
      gapCnt     <= '0;
      sclk       <= 1'b1;
      sync_n     <= 1'b1;
      din        <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            shiftReg <= frameWord;
            din      <= frameWord[FRAME_BITS-1];
            bitCnt   <= '0;
            sync_n   <= 1'b0;
            sclk     <= 1'b1;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (fallStb) begin
            sclk <= 1'b0;
          end else if (riseStb) begin
            // din only moves together with the rising edge, keeping it stable across the DAC's falling-edge capture.
            sclk <= 1'b1;
            if (bitCnt == 5'(FRAME_BITS - 1)) begin
              sync_n     <= 1'b1;
              din        <= 1'b0;
              frame_done <= 1'b1;
              gapCnt     <= '0;
              state      <= GAP;
            end else begin
              bitCnt   <= bitCnt + 5'd1;
              shiftReg <= {shiftReg[FRAME_BITS-2:0], 1'b0};
              din      <= shiftReg[FRAME_BITS-2];
            end
          end
        end
        GAP: begin
          if (gapCnt == GAP_W'(GAP_CYCLES - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gapCnt <= gapCnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (reset) !sync_n |-> state == SHIFT);

endmodule
